// File: rtl/pong_game_ctrl.sv
// Pong game-logic controller: paddles, ball, scoring and game phase.
// All game state advances once per frame, on the falling edge of vsync.
module pong_game_ctrl #(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int PADDLE_W     = 8,
    parameter int PADDLE_H     = 64,
    parameter int BALL_SIZE    = 8,
    parameter int PADDLE_SPEED = 4,
    parameter int BALL_SPEED   = 2,
    parameter int P1_X         = 16,
    parameter int P2_X         = 616,
    parameter int SCORE_MAX    = 9,
    parameter int POINT_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic       p1_up,
    input  logic       p1_down,
    input  logic       p2_up,
    input  logic       p2_down,
    input  logic       serve,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [9:0] p1_y,
    output logic [9:0] p2_y,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic [1:0] game_state
);

    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_POINT = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    // All geometry is evaluated 11 bits wide so no boundary test can wrap.
    localparam logic [10:0] BALL_X0   = 11'((H_RES - BALL_SIZE) / 2);
    localparam logic [10:0] BALL_Y0   = 11'((V_RES - BALL_SIZE) / 2);
    localparam logic [10:0] PAD_Y0    = 11'((V_RES - PADDLE_H) / 2);
    localparam logic [10:0] PAD_YMAX  = 11'(V_RES - PADDLE_H);
    localparam logic [10:0] BALL_XMAX = 11'(H_RES - BALL_SIZE);
    localparam logic [10:0] BALL_YMAX = 11'(V_RES - BALL_SIZE);
    localparam logic [10:0] PSPD      = 11'(PADDLE_SPEED);
    localparam logic [10:0] BSPD      = 11'(BALL_SPEED);
    localparam logic [10:0] BSZ       = 11'(BALL_SIZE);
    localparam logic [10:0] PH        = 11'(PADDLE_H);
    localparam logic [10:0] P1_FACE   = 11'(P1_X + PADDLE_W);
    localparam logic [10:0] P2_FACE   = 11'(P2_X);
    localparam logic [3:0]  SMAX      = 4'(SCORE_MAX);
    localparam logic [5:0]  HOLD_LAST = 6'(POINT_FRAMES - 1);

    state_t      state_q, state_d;
    logic [9:0]  ball_x_q, ball_x_d;
    logic [9:0]  ball_y_q, ball_y_d;
    logic [9:0]  p1_y_q, p1_y_d;
    logic [9:0]  p2_y_q, p2_y_d;
    logic [3:0]  score_p1_q, score_p1_d;
    logic [3:0]  score_p2_q, score_p2_d;
    logic        dx_q, dx_d;          // 0 right, 1 left
    logic        dy_q, dy_d;          // 0 down, 1 up
    logic [5:0]  cnt_q, cnt_d;
    logic        vsync_q, vsync_d;

    logic        frame_tick;
    logic [10:0] bx, by, p1w, p2w;

    assign frame_tick = vsync_q & ~vsync;
    assign bx  = {1'b0, ball_x_q};
    assign by  = {1'b0, ball_y_q};
    assign p1w = {1'b0, p1_y_q};
    assign p2w = {1'b0, p2_y_q};

    function automatic logic [9:0] paddle_step(input logic [10:0] y, input logic up, input logic dn);
        logic [10:0] r;
        r = y;
        if (up && !dn)
            r = (y > PSPD) ? y - PSPD : '0;
        else if (dn && !up)
            r = (y + PSPD < PAD_YMAX) ? y + PSPD : PAD_YMAX;
        return 10'(r);
    endfunction

    // Ball and paddle share rows; uses paddle position from before this frame's move.
    function automatic logic overlap(input logic [10:0] y, input logic [10:0] py);
        return (y + BSZ > py) && (y < py + PH);
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s >= SMAX) ? SMAX : s + 4'd1;
    endfunction

    // Next-state: game phase, ball motion, paddles and scores, once per frame tick.
    always_comb begin
        state_d    = state_q;
        ball_x_d   = ball_x_q;
        ball_y_d   = ball_y_q;
        p1_y_d     = p1_y_q;
        p2_y_d     = p2_y_q;
        score_p1_d = score_p1_q;
        score_p2_d = score_p2_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        cnt_d      = cnt_q;
        vsync_d    = vsync;
        if (frame_tick) begin
            if (state_q != ST_OVER) begin
                p1_y_d = paddle_step(p1w, p1_up, p1_down);
                p2_y_d = paddle_step(p2w, p2_up, p2_down);
            end
            case (state_q)
                ST_SERVE: begin
                    ball_x_d = 10'(BALL_X0);
                    ball_y_d = 10'(BALL_Y0);
                    if (serve) state_d = ST_PLAY;
                end
                ST_PLAY: begin
                    // A miss freezes the ball where it is; it does not move this frame.
                    if (dx_q && bx <= BSPD) begin
                        score_p2_d = sat_inc(score_p2_q);
                        dx_d       = 1'b0;
                        state_d    = ST_POINT;
                    end else if (!dx_q && bx >= BALL_XMAX - BSPD) begin
                        score_p1_d = sat_inc(score_p1_q);
                        dx_d       = 1'b1;
                        state_d    = ST_POINT;
                    end else begin
                        if (dx_q && bx >= P1_FACE && bx - BSPD <= P1_FACE && overlap(by, p1w)) begin
                            ball_x_d = 10'(P1_FACE);
                            dx_d     = 1'b0;
                        end else if (!dx_q && bx + BSZ <= P2_FACE && bx + BSZ + BSPD >= P2_FACE
                                     && overlap(by, p2w)) begin
                            ball_x_d = 10'(P2_FACE - BSZ);
                            dx_d     = 1'b1;
                        end else if (dx_q) begin
                            ball_x_d = 10'(bx - BSPD);
                        end else begin
                            ball_x_d = 10'(bx + BSPD);
                        end
                        if (dy_q && by <= BSPD) begin
                            ball_y_d = '0;
                            dy_d     = 1'b0;
                        end else if (!dy_q && by >= BALL_YMAX - BSPD) begin
                            ball_y_d = 10'(BALL_YMAX);
                            dy_d     = 1'b1;
                        end else if (dy_q) begin
                            ball_y_d = 10'(by - BSPD);
                        end else begin
                            ball_y_d = 10'(by + BSPD);
                        end
                    end
                end
                ST_POINT: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_d = '0;
                        if (score_p1_q == SMAX || score_p2_q == SMAX) begin
                            state_d = ST_OVER;
                        end else begin
                            state_d  = ST_SERVE;
                            ball_x_d = 10'(BALL_X0);
                            ball_y_d = 10'(BALL_Y0);
                        end
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                ST_OVER: begin
                    if (serve) begin
                        score_p1_d = '0;
                        score_p2_d = '0;
                        ball_x_d   = 10'(BALL_X0);
                        ball_y_d   = 10'(BALL_Y0);
                        state_d    = ST_SERVE;
                    end
                end
                default: state_d = ST_SERVE;
            endcase
        end
    end

    // State registers; async reset also clears the vsync history so release cannot fake a tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_SERVE;
            ball_x_q   <= 10'(BALL_X0);
            ball_y_q   <= 10'(BALL_Y0);
            p1_y_q     <= 10'(PAD_Y0);
            p2_y_q     <= 10'(PAD_Y0);
            score_p1_q <= '0;
            score_p2_q <= '0;
            dx_q       <= 1'b0;
            dy_q       <= 1'b0;
            cnt_q      <= '0;
            vsync_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ball_x_q   <= ball_x_d;
            ball_y_q   <= ball_y_d;
            p1_y_q     <= p1_y_d;
            p2_y_q     <= p2_y_d;
            score_p1_q <= score_p1_d;
            score_p2_q <= score_p2_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            cnt_q      <= cnt_d;
            vsync_q    <= vsync_d;
        end
    end

    assign ball_x     = ball_x_q;
    assign ball_y     = ball_y_q;
    assign p1_y       = p1_y_q;
    assign p2_y       = p2_y_q;
    assign score_p1   = score_p1_q;
    assign score_p2   = score_p2_q;
    assign game_state = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: integer game model checked every cycle, plus hand-computed waypoints.
module tb_pong_game_ctrl;

    logic       clk = 1'b0, reset = 1'b0, vsync = 1'b0;
    logic       p1_up = 1'b0, p1_down = 1'b0, p2_up = 1'b0, p2_down = 1'b0, serve = 1'b0;
    logic [9:0] ball_x, ball_y, p1_y, p2_y;
    logic [3:0] score_p1, score_p2;
    logic [1:0] game_state;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    pong_game_ctrl dut (
        .clk(clk), .reset(reset), .vsync(vsync),
        .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down), .serve(serve),
        .ball_x(ball_x), .ball_y(ball_y), .p1_y(p1_y), .p2_y(p2_y),
        .score_p1(score_p1), .score_p2(score_p2), .game_state(game_state)
    );

    always #5 clk = ~clk;

    // Game model: velocities as signed pixels per frame, phase as 0..3.
    typedef struct {
        int bx, by, p1, p2, s1, s2, st, cnt, vx, vy;
        bit vs;
    } mdl_t;
    mdl_t m;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.bx = 316; r.by = 236; r.p1 = 208; r.p2 = 208;
        r.s1 = 0; r.s2 = 0; r.st = 0; r.cnt = 0; r.vx = 2; r.vy = 2; r.vs = 1'b0;
        return r;
    endfunction

    function automatic int pad(input int p, input bit up, input bit dn);
        if (up && !dn) return (p - 4 < 0) ? 0 : p - 4;
        if (dn && !up) return (p + 4 > 416) ? 416 : p + 4;
        return p;
    endfunction

    function automatic bit hits(input int y, input int p);
        return (y + 8 > p) && (y < p + 64);
    endfunction

    function automatic mdl_t mdl_clock(input mdl_t c, input bit vs, input bit u1, input bit d1,
                                       input bit u2, input bit d2, input bit sv);
        mdl_t r;
        r = c;
        r.vs = vs;
        if (!(c.vs && !vs)) return r;
        if (c.st != 3) begin
            r.p1 = pad(c.p1, u1, d1);
            r.p2 = pad(c.p2, u2, d2);
        end
        case (c.st)
            0: begin
                r.bx = 316; r.by = 236;
                if (sv) r.st = 1;
            end
            1: begin
                if (c.vx < 0 && c.bx <= 2) begin
                    r.s2 = (c.s2 + 1 > 9) ? 9 : c.s2 + 1; r.vx = 2; r.st = 2;
                end else if (c.vx > 0 && c.bx >= 630) begin
                    r.s1 = (c.s1 + 1 > 9) ? 9 : c.s1 + 1; r.vx = -2; r.st = 2;
                end else begin
                    if (c.vx < 0 && c.bx >= 24 && c.bx - 2 <= 24 && hits(c.by, c.p1)) begin
                        r.bx = 24; r.vx = 2;
                    end else if (c.vx > 0 && c.bx + 8 <= 616 && c.bx + 10 >= 616 && hits(c.by, c.p2)) begin
                        r.bx = 608; r.vx = -2;
                    end else begin
                        r.bx = c.bx + c.vx;
                    end
                    if (c.vy < 0 && c.by <= 2) begin
                        r.by = 0; r.vy = 2;
                    end else if (c.vy > 0 && c.by >= 470) begin
                        r.by = 472; r.vy = -2;
                    end else begin
                        r.by = c.by + c.vy;
                    end
                end
            end
            2: begin
                if (c.cnt == 59) begin
                    r.cnt = 0;
                    if (c.s1 == 9 || c.s2 == 9) r.st = 3;
                    else begin r.st = 0; r.bx = 316; r.by = 236; end
                end else begin
                    r.cnt = c.cnt + 1;
                end
            end
            default: begin
                if (sv) begin
                    r.s1 = 0; r.s2 = 0; r.bx = 316; r.by = 236; r.st = 0;
                end
            end
        endcase
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= mdl_reset();
        else       m <= mdl_clock(m, vsync, p1_up, p1_down, p2_up, p2_down, serve);
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Every cycle out of reset the DUT must agree with the model.
    always @(negedge clk) begin
        if (chk_en && !reset) begin
            check("m_ball_x", ball_x, m.bx);
            check("m_ball_y", ball_y, m.by);
            check("m_p1_y", p1_y, m.p1);
            check("m_p2_y", p2_y, m.p2);
            check("m_score_p1", score_p1, m.s1);
            check("m_score_p2", score_p2, m.s2);
            check("m_state", game_state, m.st);
        end
    end

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) vsync = 1'b1;
            @(negedge clk);
            @(negedge clk) vsync = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic expect_all(input string tag, input int bx, input int by, input int q1, input int q2,
                              input int s1, input int s2, input int st);
        check({tag, "_ball_x"}, ball_x, bx);
        check({tag, "_ball_y"}, ball_y, by);
        check({tag, "_p1_y"}, p1_y, q1);
        check({tag, "_p2_y"}, p2_y, q2);
        check({tag, "_score_p1"}, score_p1, s1);
        check({tag, "_score_p2"}, score_p2, s2);
        check({tag, "_state"}, game_state, st);
    endtask

    // Left player keeps its paddle centred on the ball.
    task automatic track();
        int t;
        t = m.by - 28;
        p1_up   = (m.p1 > t + 2);
        p1_down = (m.p1 < t - 2);
    endtask

    initial begin
        int sp1, sp2, sbx, sby, budget;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;
        expect_all("rst", 316, 236, 208, 208, 0, 0, 0);

        frames(5);
        expect_all("idle", 316, 236, 208, 208, 0, 0, 0);

        p1_up = 1'b1;
        frames(1);  check("p1_up_1", p1_y, 204);
        frames(51); check("p1_up_52", p1_y, 0);
        frames(8);  check("p1_top_clamp", p1_y, 0);
        p1_up = 1'b0; p1_down = 1'b1;
        frames(3);  check("p1_down_3", p1_y, 12);
        p1_up = 1'b1;
        frames(2);  check("p1_both", p1_y, 12);
        p1_up = 1'b0;
        frames(30); check("p1_down_33", p1_y, 132);
        p1_down = 1'b0; p2_down = 1'b1;
        frames(80); check("p2_bot_clamp", p2_y, 416);
        p2_down = 1'b0;

        serve = 1'b1; frames(1); serve = 1'b0;
        check("serve_state", game_state, 1);
        check("serve_ball_x", ball_x, 316);
        frames(1);   check("play1_x", ball_x, 318);   check("play1_y", ball_y, 238);
        frames(116); check("pre_wall_x", ball_x, 550); check("pre_wall_y", ball_y, 470);
        frames(1);   check("wall_x", ball_x, 552);     check("wall_y", ball_y, 472);
        frames(1);   check("post_wall_y", ball_y, 470);
        frames(27);  check("p2_hit_x", ball_x, 608);   check("p2_hit_y", ball_y, 416);
        frames(292); check("p1_hit_x", ball_x, 24);    check("p1_hit_y", ball_y, 168);
        frames(304);
        expect_all("miss", 630, 170, 132, 416, 1, 0, 2);
        frames(59);  check("hold_state", game_state, 2);
        frames(1);
        expect_all("resume", 316, 236, 132, 416, 1, 0, 0);

        for (int r = 0; r < 8; r++) begin
            serve = 1'b1; frames(1); serve = 1'b0;
            budget = 0;
            while (m.st == 1 && budget < 3000) begin
                track();
                frames(1);
                budget++;
            end
            p1_up = 1'b0; p1_down = 1'b0;
            check("rally_end_state", game_state, 2);
            frames(60);
        end
        check("over_state", game_state, 3);
        check("over_score_p1", score_p1, 9);
        check("over_score_p2", score_p2, 0);

        sp1 = m.p1; sp2 = m.p2; sbx = m.bx; sby = m.by;
        p1_up = 1'b1; p2_up = 1'b1;
        frames(5);
        p1_up = 1'b0; p2_up = 1'b0;
        check("over_p1_frozen", p1_y, sp1);
        check("over_p2_frozen", p2_y, sp2);
        check("over_ball_x", ball_x, sbx);
        check("over_ball_y", ball_y, sby);
        serve = 1'b1; frames(1); serve = 1'b0;
        check("restart_state", game_state, 0);
        check("restart_s1", score_p1, 0);
        check("restart_ball_x", ball_x, 316);
        check("restart_ball_y", ball_y, 236);

        serve = 1'b1; frames(1); serve = 1'b0;
        frames(10);
        check("pre_reset_state", game_state, 1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 expect_all("async_rst", 316, 236, 208, 208, 0, 0, 0);
        @(negedge clk) reset = 1'b0;
        frames(3);
        expect_all("post_rst", 316, 236, 208, 208, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("%0d/%0d checks passed", n_pass, n_chk + 1);
        $fatal(1, "watchdog");
    end

endmodule
